// File: rtl/response_capture_pkg.sv
// -----------------------------------------------------------------------------
// response_capture_pkg
// Shared definitions for the response capture block that feeds the 11-bit
// Response PIO: the capture FSM state encoding and the default widths.
// Ports: none (package).
// Configuration macro used by the block: RESP_STABLE_CHECK_EN.
// -----------------------------------------------------------------------------
package response_capture_pkg;

    localparam int RESP_W  = 11;   // default response word width (PIO in_port)
    localparam int COUNT_W = 16;   // capture counter and internal counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/response_capture_resp_sync.sv
// -----------------------------------------------------------------------------
// resp_sync
// WIDTH-bit two-flop synchronizer bringing the asynchronous DUT response pins
// into the clk domain. Each bit is synchronized independently, so a multi-bit
// word is only coherent once the pins have been stable for two clk cycles.
// Ports:
//   clk_i    in   1      capture clock
//   rst_ni   in   1      asynchronous active-low reset (both stages clear to 0)
//   d_i      in   WIDTH  raw asynchronous pins
//   q_o      out  WIDTH  synchronized pins
// -----------------------------------------------------------------------------
module resp_sync
    import response_capture_pkg::*;
#(
    parameter int WIDTH = RESP_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/response_capture.sv
// -----------------------------------------------------------------------------
// response_capture
// Samples the asynchronous DUT response pins after a programmable settle time
// and holds the captured word stable on out_port for CPU readback through the
// Response PIO. A start pulse arms a capture; done stays high with the word
// valid until clear returns the block to idle.
// Ports:
//   clk            in   1        single clock, posedge
//   reset_n        in   1        asynchronous active-low reset
//   start          in   1        one-cycle capture request, honoured only in IDLE
//   clear          in   1        synchronous return to IDLE, highest priority
//   dut_resp       in   WIDTH    raw DUT response pins (asynchronous)
//   out_port       out  WIDTH    captured word (drives PIO in_port)
//   busy           out  1        high while settling or sampling
//   done           out  1        high while the captured word is valid
//   unstable       out  1        stability window expired (0 without the macro)
//   capture_count  out  COUNT_W  completed captures, wraps 0xFFFF -> 0
// Configuration:
//   RESP_STABLE_CHECK_EN  when defined, SAMPLE waits for STABLE_CYCLES
//                         consecutive identical samples, bounded by MAX_SAMPLE
//                         cycles; otherwise SAMPLE lasts a single cycle.
// -----------------------------------------------------------------------------
module response_capture
    import response_capture_pkg::*;
#(
    parameter int WIDTH         = RESP_W,
    parameter int SETTLE_CYCLES = 4
`ifdef RESP_STABLE_CHECK_EN
    ,
    parameter int STABLE_CYCLES = 3,
    parameter int MAX_SAMPLE    = 64
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               clear,
    input  logic [WIDTH-1:0]   dut_resp,
    output logic [WIDTH-1:0]   out_port,
    output logic               busy,
    output logic               done,
    output logic               unstable,
    output logic [COUNT_W-1:0] capture_count
);

    // Last settle count before moving to SAMPLE; unused when SETTLE_CYCLES is 0
    // because IDLE then jumps straight to SAMPLE.
    localparam logic [COUNT_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? COUNT_W'(SETTLE_CYCLES - 1) : '0;

    logic [WIDTH-1:0]   sync_w;

    state_e             state_q,   state_d;
    logic [COUNT_W-1:0] settle_q,  settle_d;
    logic [WIDTH-1:0]   word_q,    word_d;
    logic [COUNT_W-1:0] cap_cnt_q, cap_cnt_d;

    resp_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (dut_resp),
        .q_o    (sync_w)
    );

`ifdef RESP_STABLE_CHECK_EN
    // Match counter value that, with one more equal sample, completes the
    // required run of STABLE_CYCLES equal samples.
    localparam logic [COUNT_W-1:0] STABLE_LAST = COUNT_W'(STABLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WIN_LAST    = COUNT_W'(MAX_SAMPLE - 1);

    logic [WIDTH-1:0]   prev_q,     prev_d;
    logic [COUNT_W-1:0] match_q,    match_d;
    logic [COUNT_W-1:0] win_q,      win_d;
    logic               unstable_q, unstable_d;
    logic               same_w;

    // The first SAMPLE cycle has no previous sample to compare against.
    assign same_w = (win_q != '0) && (sync_w == prev_q);
`endif

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        word_d    = word_q;
        cap_cnt_d = cap_cnt_q;
`ifdef RESP_STABLE_CHECK_EN
        prev_d     = prev_q;
        match_d    = match_q;
        win_d      = win_q;
        unstable_d = unstable_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
`ifdef RESP_STABLE_CHECK_EN
                    match_d = '0;
                    win_d   = '0;
`endif
                end
            end

            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + COUNT_W'(1);
                end
            end

            ST_SAMPLE: begin
`ifdef RESP_STABLE_CHECK_EN
                prev_d = sync_w;
                win_d  = win_q + COUNT_W'(1);
                if (same_w && (match_q == STABLE_LAST)) begin
                    word_d     = sync_w;
                    cap_cnt_d  = cap_cnt_q + COUNT_W'(1);
                    unstable_d = 1'b0;
                    state_d    = ST_DONE;
                end else if (win_q == WIN_LAST) begin
                    // Window exhausted: keep the most recent sample, flag it.
                    word_d     = sync_w;
                    cap_cnt_d  = cap_cnt_q + COUNT_W'(1);
                    unstable_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    match_d = same_w ? (match_q + COUNT_W'(1)) : '0;
                end
`else
                word_d    = sync_w;
                cap_cnt_d = cap_cnt_q + COUNT_W'(1);
                state_d   = ST_DONE;
`endif
            end

            ST_DONE: begin
                // Held until clear; start is deliberately ignored here.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // clear overrides everything, including a same-cycle start and an
        // in-flight SAMPLE exit: the word and the count must not move.
        if (clear) begin
            state_d   = ST_IDLE;
            word_d    = word_q;
            cap_cnt_d = cap_cnt_q;
`ifdef RESP_STABLE_CHECK_EN
            unstable_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            word_q    <= '0;
            cap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            word_q    <= word_d;
            cap_cnt_q <= cap_cnt_d;
        end
    end

`ifdef RESP_STABLE_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            match_q    <= '0;
            win_q      <= '0;
            unstable_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            match_q    <= match_d;
            win_q      <= win_d;
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = 1'b0;
`endif

    assign out_port      = word_q;
    assign busy          = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done          = (state_q == ST_DONE);
    assign capture_count = cap_cnt_q;

endmodule

// File: tb/tb_response_capture.sv
module tb_response_capture;

    localparam int W      = 11;
    localparam int SETTLE = 4;
`ifdef RESP_STABLE_CHECK_EN
    localparam int STABLE = 3;
    localparam int MAXS   = 64;
    localparam int LAT    = SETTLE + STABLE + 1;
`else
    localparam int LAT    = SETTLE + 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          clear;
    logic [W-1:0]  dut_resp;
    logic [W-1:0]  out_port;
    logic          busy;
    logic          done;
    logic          unstable;
    logic [15:0]   capture_count;

    always #5 clk = ~clk;

    response_capture #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .clear         (clear),
        .dut_resp      (dut_resp),
        .out_port      (out_port),
        .busy          (busy),
        .done          (done),
        .unstable      (unstable),
        .capture_count (capture_count)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic tog_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] resp;
        logic [W-1:0] mask;
        logic [15:0]  cnt;
        logic         unst;
        int           due;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising edge of done is a presented capture.
    logic done_prev = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (reset_n && done && !done_prev) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: out_port 0x%0h with no capture expected (cycle %0d)",
                         out_port, cyc);
            end else begin
                e = sbq.pop_front();
                chk("cap_word",     32'(out_port & e.mask), 32'(e.resp & e.mask));
                chk("cap_count",    32'(capture_count),     32'(e.cnt));
                chk("cap_unstable", 32'(unstable),          32'(e.unst));
                chk("cap_latency",  32'(cyc),               32'(e.due));
            end
        end
        done_prev <= done;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int acc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc   = cyc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", bound);
        end
        tick(1);
    endtask

    task automatic capture(input logic [W-1:0] resp, input logic [15:0] cnt, input logic do_clr);
        int acc;
        exp_t x;
        dut_resp = resp;
        tick(3);
        pulse_start(acc);
        x.resp = resp; x.mask = '1; x.cnt = cnt; x.unst = 1'b0; x.due = acc + LAT;
        sbq.push_back(x);
        wait_done(200);
        if (do_clr) do_clear();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc;
        exp_t x;
        reset_n  = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        dut_resp = 11'h7FF;

        // 1: reset state with all pins high
        tick(3);
        chk("rst_out_port", 32'(out_port),      32'h0);
        chk("rst_done",     32'(done),          32'h0);
        chk("rst_busy",     32'(busy),          32'h0);
        chk("rst_unstable", 32'(unstable),      32'h0);
        chk("rst_count",    32'(capture_count), 32'h0);
        reset_n = 1'b1;
        tick(2);

        // 2: basic capture
        dut_resp = 11'h5A3;
        tick(3);
        pulse_start(acc);
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("done_after_start", 32'(done), 32'h0);
        x.resp = 11'h5A3; x.mask = '1; x.cnt = 16'd1; x.unst = 1'b0; x.due = acc + LAT;
        sbq.push_back(x);
        wait_done(200);

        // 3: start ignored in DONE, then clear
        dut_resp = 11'h001;
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(LAT + 3);
        chk("hold_done",  32'(done),          32'h1);
        chk("hold_word",  32'(out_port),      32'h5A3);
        chk("hold_count", 32'(capture_count), 32'd1);
        chk("hold_busy",  32'(busy),          32'h0);
        do_clear();
        chk("clr_done",  32'(done),          32'h0);
        chk("clr_busy",  32'(busy),          32'h0);
        chk("clr_word",  32'(out_port),      32'h5A3);
        chk("clr_count", 32'(capture_count), 32'd1);

        // 4: abort in the middle of SETTLE
        dut_resp = 11'h0F0;
        tick(3);
        pulse_start(acc);
        tick(2);
        do_clear();
        chk("abort_busy",  32'(busy),          32'h0);
        chk("abort_done",  32'(done),          32'h0);
        chk("abort_word",  32'(out_port),      32'h5A3);
        chk("abort_count", 32'(capture_count), 32'd1);
        tick(LAT + 5);
        chk("abort_stays_idle", 32'(done),     32'h0);
        chk("abort_word_late",  32'(out_port), 32'h5A3);

        // 5: further patterns and counter wrap
        capture(11'h0F0, 16'd2, 1'b1);
        capture(11'h2AA, 16'd3, 1'b1);
        dut.cap_cnt_q <= 16'hFFFE;
        tick(1);
        capture(11'h3C3, 16'hFFFF, 1'b1);
        capture(11'h7FF, 16'h0000, 1'b1);
        start = 1'b1;
        clear = 1'b1;
        tick(1);
        start = 1'b0;
        clear = 1'b0;
        chk("clr_start_busy", 32'(busy), 32'h0);
        tick(LAT + 5);
        chk("clr_start_done",  32'(done),          32'h0);
        chk("clr_start_count", 32'(capture_count), 32'h0);
        chk("clr_start_word",  32'(out_port),      32'h7FF);

`ifdef RESP_STABLE_CHECK_EN
        // 6: toggling bit0 never settles -> window expires, unstable flagged
        dut_resp = 11'h155;
        tog_en   = 1'b1;
        fork
            begin
                for (int i = 0; i < 400 && tog_en; i++) begin
                    @(posedge clk);
                    #1;
                    dut_resp[0] = ~dut_resp[0];
                end
            end
        join_none
        tick(3);
        pulse_start(acc);
        x.resp = 11'h155; x.mask = 11'h7FE; x.cnt = 16'd1; x.unst = 1'b1;
        x.due  = acc + SETTLE + MAXS;
        sbq.push_back(x);
        wait_done(200);
        tog_en = 1'b0;
        tick(2);
        chk("unst_held", 32'(unstable), 32'h1);
        do_clear();
        chk("unst_cleared", 32'(unstable), 32'h0);
        capture(11'h2AA, 16'd2, 1'b1);
`endif

        tick(4);
        chk("queue_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
